// File: rtl/iterative_divider_64_32.sv
// iterative_divider_64_32: 64/32 unsigned restoring divider, one quotient bit per cycle.
module iterative_divider_64_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [31:0] B,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [31:0] b_q, b_d, rem_q, rem_d, lo_q, lo_d, quo_q, quo_d, q_q, q_d, r_q, r_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [32:0] trial, diff;
  logic [31:0] rem_nx, quo_nx;
  logic        borrow;
  always_comb begin
    trial  = {rem_q, lo_q[31]};
    diff   = trial - {1'b0, b_q};
    borrow = diff[32];
    rem_nx = borrow ? trial[31:0] : diff[31:0];
    quo_nx = {quo_q[30:0], ~borrow};
  end
  // done lags an exceptional result by one edge so both paths see done after a full step
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = state_q == DONE;
    case (state_q)
      IDLE, DONE: if (start) begin
        b_d    = B;
        lo_d   = A[31:0];
        rem_d  = A[63:32];
        quo_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        dbz_d  = B == '0;
        ovf_d  = B != '0 && A[63:32] >= B;
        q_d    = (B == '0 || A[63:32] >= B) ? '1 : q_q;
        r_d    = B == '0 ? A[31:0] : A[63:32] >= B ? '0 : r_q;
        state_d = (B == '0 || A[63:32] >= B) ? DONE : RUN;
      end
      RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        lo_d  = {lo_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          q_d     = quo_nx;
          r_d     = rem_nx;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign Q    = q_q;
  assign R    = r_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_iterative_divider_64_32.sv
// tb_iterative_divider_64_32: directed and random self-checking bench for the 64/32 divider.
module tb_iterative_divider_64_32;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [31:0] q, r;
  logic        busy, done, dbz, ovf;
  int          checks = 0, errors = 0;
  int          lat, bcnt;

  iterative_divider_64_32 dut (
    .clk(clk), .rst(rst), .start(start), .A(a_i), .B(b_i),
    .Q(q), .R(r), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start at the next edge, then count edges until done (bounded) and busy cycles seen
  task automatic run(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    a_i = a; b_i = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input logic eovf, input int elat);
    check({tag, " Q"}, 64'(q), 64'(eq));
    check({tag, " R"}, 64'(r), 64'(er));
    check({tag, " dbz"}, 64'(dbz), 64'(edbz));
    check({tag, " ovf"}, 64'(ovf), 64'(eovf));
    check({tag, " lat"}, 64'(lat), 64'(elat));
  endtask

  task automatic expect_zero(input string tag);
    check({tag, " Q"}, 64'(q), 64'd0);
    check({tag, " R"}, 64'(r), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " dbz"}, 64'(dbz), 64'd0);
    check({tag, " ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rb;
    repeat (2) @(posedge clk);
    #1 expect_zero("reset");
    @(negedge clk) rst = 1'b0;

    run(64'd100, 32'd7);
    expect_result("basic", 32'd14, 32'd2, 1'b0, 1'b0, 32);
    check("basic busy cycles", 64'(bcnt), 64'd32);

    run(64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
    expect_result("inv1", 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 32);
    run(64'h00000001_00000000, 32'h00010000);
    expect_result("inv2", 32'h00010000, 32'd0, 1'b0, 1'b0, 32);

    run(64'h0000_0000_1234_5678, 32'd0);
    expect_result("dbz", 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1);
    check("dbz busy cycles", 64'(bcnt), 64'd0);
    a_i = 64'd55; b_i = 32'd9;
    repeat (3) @(posedge clk);
    #1 check("dbz hold Q", 64'(q), 64'hFFFFFFFF);
    check("dbz hold done", 64'(done), 64'd1);

    run(64'h00000005_00000000, 32'd5);
    expect_result("ovf", 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1);
    check("ovf busy cycles", 64'(bcnt), 64'd0);

    @(negedge clk);
    a_i = 64'd100; b_i = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("abort busy before rst", 64'(busy), 64'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 expect_zero("abort");
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 expect_zero("rst over start");
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    run(64'd1000, 32'd3);
    expect_result("fresh", 32'd333, 32'd1, 1'b0, 1'b0, 32);

    @(negedge clk);
    a_i = 64'd123456789; b_i = 32'd1000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) begin a_i = 64'd5; b_i = 32'd0; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    check("ignored start busy", 64'(busy), 64'd1);
    check("ignored start dbz", 64'(dbz), 64'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored Q", 64'(q), 64'd123456);
    check("ignored R", 64'(r), 64'd789);
    check("ignored dbz", 64'(dbz), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      rb = $urandom;
      if (rb == 0) rb = 32'd1;
      ra = {32'($urandom) % rb, 32'($urandom)};
      run(ra, rb);
      check("rand Q", 64'(q), ra / 64'(rb));
      check("rand R", 64'(r), ra % 64'(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_divider_64_32.md
ITERATIVE_DIVIDER_64_32 -- requirements
Module: iterative_divider_64_32

Interface
REQ-001 SHALL have a clock input: clk, input, 1 bit.
REQ-002 SHALL have a reset input: rst, input, 1 bit; synchronous, active-high.
REQ-003 SHALL have a start input: start, input, 1 bit; one-cycle request to begin a division.
REQ-004 SHALL have a dividend input: A, input, 64 bits; unsigned dividend, e.g. a product from the iterative Karatsuba multiplier.
REQ-005 SHALL have a divisor input: B, input, 32 bits; unsigned divisor.
REQ-006 SHALL have a quotient output: Q, output, 32 bits; registered.
REQ-007 SHALL have a remainder output: R, output, 32 bits; registered.
REQ-008 SHALL have a busy output: busy, output, 1 bit; high while an iteration is in progress.
REQ-009 SHALL have a done output: done, output, 1 bit; level signal, high while the result is valid.
REQ-010 SHALL have a divide-by-zero flag: dbz, output, 1 bit; high when B was 0 at start.
REQ-011 SHALL have an overflow flag: ovf, output, 1 bit; high when the quotient cannot fit in 32 bits.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE, each with a distinct encoding.
REQ-013 SHALL accept start only in IDLE or DONE; start SHALL be ignored in RUN.
REQ-014 SHALL, on accepted start, capture A and B into internal registers, clear done/dbz/ovf, and clear the quotient shift register; later changes to A and B SHALL NOT affect the result.
REQ-015 SHALL, on accepted start with B==0, go directly to DONE with dbz=1, Q=32'hFFFFFFFF, R=A[31:0].
REQ-016 SHALL, on accepted start with B!=0 and A[63:32]>=B, go directly to DONE with ovf=1, Q=32'hFFFFFFFF, R=0.
REQ-017 SHALL otherwise load the partial remainder with A[63:32] and enter RUN with busy=1.
REQ-018 SHALL perform one restoring step per RUN cycle, 32 steps in total, consuming dividend bits A[31:0] MSB first.
REQ-019 Each step SHALL form a 33-bit value, trial = {partial_rem, next dividend bit}.
REQ-020 Each step SHALL compute the 33-bit difference trial - {1'b0,B}.
REQ-021 When the difference has no borrow, the step SHALL make partial_rem equal to the difference and shift a 1 into the quotient.
REQ-022 When the difference borrows, the step SHALL make partial_rem equal to trial[31:0] and shift a 0 into the quotient.
REQ-023 SHALL use the iteration counter as a 6-bit count, 0..31; after the 32nd step it SHALL move to DONE, drive Q and R from the final registers, set busy=0 and done=1.
REQ-024 Latency: start accepted at edge N SHALL give done=1 after edge N+32 (normal path) or after edge N+1 (dbz/ovf path).
REQ-025 In DONE, SHALL hold Q, R, dbz, ovf and done stable until the next accepted start or rst.
REQ-026 A start in DONE SHALL begin a new division in the same way as from IDLE (back-to-back operation).
REQ-027 The result SHALL satisfy A == Q*B + R and R < B for every non-exceptional case.

Reset
REQ-028 When rst=1 at a clk edge, the state SHALL become IDLE and Q, R, busy, done, dbz and ovf SHALL become 0, counter and internal registers SHALL clear, and any division in progress SHALL be discarded.
REQ-029 rst SHALL take priority over start on the same edge.
REQ-030 After rst is released, the first accepted start SHALL produce a correct result with no leftover state from the aborted operation.

Verification
REQ-031 Scenario basic: A=64'd100, B=32'd7 -> Q=14, R=2, dbz=0, ovf=0; done rises 32 edges after the start edge; busy is high for exactly 32 cycles.
REQ-032 Scenario inverse of multiplier: A=64'hFFFFFFFE_00000001, B=32'hFFFFFFFF -> Q=32'hFFFFFFFF, R=0. A second case, A=64'h00000001_00000000, B=32'h00010000 -> Q=32'h00010000, R=0.
REQ-033 Scenario divide-by-zero: A=64'h0000_0000_1234_5678, B=0 -> dbz=1, Q=32'hFFFFFFFF, R=32'h12345678, done one edge after start, busy never high.
REQ-034 Scenario overflow: A=64'h00000005_00000000, B=5 -> ovf=1, Q=32'hFFFFFFFF, R=0, done one edge after start.
REQ-035 Scenario abort and ignored start: rst asserted during RUN step 10 -> all outputs 0 next cycle. A fresh start with A=1000, B=3 -> Q=333, R=1. A start pulse with changed A/B in mid-RUN -> no effect on the result.
REQ-036 Scenario randomized: at least 1000 random (A with A[63:32]<B, B!=0) pairs, issued back-to-back from DONE -> each result matches a reference model, Q=A/B and R=A%B.
